// File: rtl/ifetch_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding TCM word read feeding a DEPTH-entry FIFO to the core.
// Head is registered (visible the cycle after i_resp); issue stalls when FIFO plus in-flight read would exceed DEPTH.
module ifetch_prefetch_buffer #(
  parameter int               XLEN        = 32,
  parameter int               BUS_WIDTH   = 32,
  parameter int               BUS_ACC_CNT = 4,
  parameter int               DEPTH       = 4,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int               ACC_WORD    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           redirect,
  input  logic [XLEN-1:0]                redirect_pc,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  output logic [31:0]                    instr_data,
  output logic [XLEN-1:0]                instr_pc,
  output logic                           instr_fault,
  output logic [XLEN-1:0]                i_addr,
  output logic                           i_w_rb,
  output logic [$clog2(BUS_ACC_CNT)-1:0] i_acc,
  output logic [BUS_WIDTH-1:0]           i_wdata,
  output logic                           i_req,
  input  logic [BUS_WIDTH-1:0]           i_rdata,
  input  logic                           i_resp,
  input  logic                           i_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(BUS_ACC_CNT);

  typedef enum logic [1:0] {FETCH, HALT, DRAIN} state_t;

  typedef struct packed {
    logic [31:0]     data;
    logic [XLEN-1:0] pc;
    logic            fault;
  } entry_t;

  state_t          state_q, state_d;
  logic            req_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] fetch_pc_q;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic            push, pop, issue;
  logic [CW-1:0]   count_after;
  logic [XLEN-1:0] issue_pc;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // next state; redirect outranks everything
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (req_q && !i_resp) ? DRAIN : FETCH;
    end else begin
      unique case (state_q)
        FETCH:   if (req_q && i_resp && i_fault) state_d = HALT;
        DRAIN:   if (i_resp) state_d = FETCH;
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  // control outputs of the FSM
  always_comb begin
    pop         = instr_valid && instr_ready && !redirect;
    push        = req_q && i_resp && !redirect && (state_q == FETCH);
    count_after = redirect ? '0 : (count + CW'(push) - CW'(pop));
    issue_pc    = redirect ? (redirect_pc & ~XLEN'(3)) : fetch_pc_q;
    // a new read may start on the edge that ends the response cycle
    issue       = (state_d == FETCH) && (!req_q || i_resp) && (count_after < CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      req_q <= (req_q && !i_resp) || issue;
      if (issue) begin
        addr_q     <= issue_pc;
        fetch_pc_q <= issue_pc + XLEN'(4);
      end else begin
        fetch_pc_q <= issue_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_after;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= '{data: i_rdata[31:0], pc: addr_q, fault: i_fault};
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign instr_valid = (count != '0);
  assign instr_data  = mem[rd_ptr].data;
  assign instr_pc    = mem[rd_ptr].pc;
  assign instr_fault = mem[rd_ptr].fault;

  assign i_req   = req_q;
  assign i_addr  = addr_q;
  assign i_w_rb  = 1'b0;
  assign i_acc   = AW'(ACC_WORD);
  assign i_wdata = '0;

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Directed bench for ifetch_prefetch_buffer with a simple TCM responder of programmable latency.
module tb_ifetch_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic [31:0] i_addr;
  logic        i_w_rb;
  logic [1:0]  i_acc;
  logic [31:0] i_wdata;
  logic        i_req;
  logic [31:0] i_rdata = '0;
  logic        i_resp = 1'b0;
  logic        i_fault = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  int          lat = 1;
  int          cnt = 0;
  logic        fault_en = 1'b0;
  logic [31:0] fault_addr = '0;

  logic [31:0] addr_log [$];
  logic [31:0] got_pc   [$];
  logic [31:0] got_data [$];
  logic        got_fault[$];

  int ab, gb;

  ifetch_prefetch_buffer dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_fault(instr_fault),
    .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc), .i_wdata(i_wdata),
    .i_req(i_req), .i_rdata(i_rdata), .i_resp(i_resp), .i_fault(i_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // TCM model: response 'lat' cycles after a request is first seen
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      i_resp = 1'b0; i_fault = 1'b0; cnt = 0;
    end else if (i_resp) begin
      i_resp = 1'b0; i_fault = 1'b0;
      if (i_req) begin cnt = 1; addr_log.push_back(i_addr); end
      else cnt = 0;
    end else if (i_req) begin
      if (cnt == 0) begin
        cnt = 1; addr_log.push_back(i_addr);
      end else if (cnt >= lat) begin
        i_resp  = 1'b1;
        i_rdata = rd_of(i_addr);
        i_fault = fault_en && (i_addr == fault_addr);
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
      got_fault.push_back(instr_fault);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic restart(input logic rdy, input int l);
    rst = 1'b1; redirect = 1'b0; instr_ready = rdy; lat = l; fault_en = 1'b0;
    cyc(); cyc();
    ab = addr_log.size(); gb = got_pc.size();
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_req",   i_req, 0);
    chk("rst_addr",  i_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_data",  instr_data, 0);
    chk("rst_pc",    instr_pc, 0);
    chk("rst_fault", instr_fault, 0);
    chk("const_wrb", i_w_rb, 0);
    chk("const_acc", i_acc, 2);
    chk("const_wd",  i_wdata, 0);

    // 1: streaming with ready held high
    ab = addr_log.size(); gb = got_pc.size();
    rst = 1'b0;
    for (int k = 0; k < 100 && got_pc.size() < gb + 3; k++) cyc();
    chk("t1_wait", (got_pc.size() >= gb + 3) ? 1 : 0, 1);
    chk("t1_addr0", addr_log[ab],   32'h0);
    chk("t1_addr1", addr_log[ab+1], 32'h4);
    chk("t1_addr2", addr_log[ab+2], 32'h8);
    chk("t1_pc0",   got_pc[gb],     32'h0);
    chk("t1_pc1",   got_pc[gb+1],   32'h4);
    chk("t1_pc2",   got_pc[gb+2],   32'h8);
    chk("t1_data1", got_data[gb+1], rd_of(32'h4));
    chk("t1_flt2",  got_fault[gb+2], 0);

    // 2: FIFO fills, issue stops at DEPTH, a single pop frees one slot
    restart(1'b0, 1);
    repeat (20) cyc();
    chk("t2_reads",  addr_log.size() - ab, 4);
    chk("t2_req0",   i_req, 0);
    chk("t2_valid",  instr_valid, 1);
    chk("t2_head",   instr_pc, 32'h0);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    chk("t2_req1",   i_req, 1);
    chk("t2_addr",   i_addr, 32'h10);
    chk("t2_head1",  instr_pc, 32'h4);
    chk("t2_pops",   got_pc.size() - gb, 1);
    repeat (10) cyc();
    chk("t2_reads5", addr_log.size() - ab, 5);
    chk("t2_req2",   i_req, 0);

    // 3: redirect while 0x8 is outstanding with slow response
    restart(1'b1, 3);
    for (int k = 0; k < 100 && addr_log.size() < ab + 3; k++) cyc();
    chk("t3_wait0", (addr_log.size() >= ab + 3) ? 1 : 0, 1);
    redirect = 1'b1; redirect_pc = 32'h103;
    cyc();
    redirect = 1'b0;
    chk("t3_valid", instr_valid, 0);
    chk("t3_hreq",  i_req, 1);
    chk("t3_haddr", i_addr, 32'h8);
    chk("t3_pops",  got_pc.size() - gb, 1);
    for (int k = 0; k < 100 && addr_log.size() < ab + 4; k++) cyc();
    chk("t3_wait1", (addr_log.size() >= ab + 4) ? 1 : 0, 1);
    chk("t3_naddr", addr_log[ab+3], 32'h100);
    chk("t3_empty", instr_valid, 0);
    for (int k = 0; k < 100 && got_pc.size() < gb + 2; k++) cyc();
    chk("t3_pc",    got_pc[gb+1], 32'h100);
    chk("t3_data",  got_data[gb+1], rd_of(32'h100));

    // 4: redirect in the same cycle as the response for 0x4
    restart(1'b1, 1);
    for (int k = 0; k < 100 && !(i_resp && addr_log.size() >= ab + 2); k++) cyc();
    chk("t4_wait",  (i_resp && addr_log.size() >= ab + 2) ? 1 : 0, 1);
    redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    chk("t4_req",   i_req, 1);
    chk("t4_addr",  i_addr, 32'h200);
    chk("t4_valid", instr_valid, 0);
    for (int k = 0; k < 100 && got_pc.size() < gb + 2; k++) cyc();
    chk("t4_pc0",   got_pc[gb],   32'h0);
    chk("t4_pc1",   got_pc[gb+1], 32'h200);

    // 5: bus fault on 0xC halts fetching
    restart(1'b1, 1);
    fault_en = 1'b1; fault_addr = 32'hC;
    for (int k = 0; k < 100 && got_pc.size() < gb + 4; k++) cyc();
    chk("t5_wait",  (got_pc.size() >= gb + 4) ? 1 : 0, 1);
    chk("t5_pc2",   got_pc[gb+2], 32'h8);
    chk("t5_flt2",  got_fault[gb+2], 0);
    chk("t5_pc3",   got_pc[gb+3], 32'hC);
    chk("t5_flt3",  got_fault[gb+3], 1);
    chk("t5_dat3",  got_data[gb+3], rd_of(32'hC));
    repeat (10) cyc();
    chk("t5_req",   i_req, 0);
    chk("t5_reads", addr_log.size() - ab, 4);
    chk("t5_valid", instr_valid, 0);
    fault_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect = 1'b0;
    chk("t5_rreq",  i_req, 1);
    chk("t5_raddr", i_addr, 32'h40);

    // 6: address wrap, then reset in the middle of a read
    ab = addr_log.size(); gb = got_pc.size();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    for (int k = 0; k < 100 && got_pc.size() < gb + 2; k++) cyc();
    chk("t6_wait",  (got_pc.size() >= gb + 2) ? 1 : 0, 1);
    chk("t6_addr0", addr_log[ab],   32'hFFFF_FFFC);
    chk("t6_addr1", addr_log[ab+1], 32'h0);
    chk("t6_pc0",   got_pc[gb],     32'hFFFF_FFFC);
    chk("t6_pc1",   got_pc[gb+1],   32'h0);
    lat = 3;
    for (int k = 0; k < 100 && !(i_req && !i_resp && i_addr > 32'h10); k++) cyc();
    rst = 1'b1;
    #1;
    chk("t6_rreq",   i_req, 0);
    chk("t6_raddr",  i_addr, 32'h0);
    chk("t6_rvalid", instr_valid, 0);
    cyc(); cyc();
    ab = addr_log.size(); gb = got_pc.size();
    rst = 1'b0;
    for (int k = 0; k < 100 && got_pc.size() < gb + 1; k++) cyc();
    chk("t6_first", addr_log[ab], 32'h0);
    chk("t6_gpc",   got_pc[gb],   32'h0);
    chk("t6_gdat",  got_data[gb], rd_of(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
